sdram_ctrl: RTL and testbench

- Initiator side of the board SDRAM interface: turns single 32-bit word requests from the core-side memory bus into SDR SDRAM command sequences for a 16-bit, 4-bank, 13-row/9-column device.
- Runs the power-up init sequence, periodic auto-refresh and close-page accesses: ACTIVE, READ/WRITE burst of 2 halfwords, PRECHARGE.
- Sits between the bus arbiter and the top-level dq tristate.

---
 rtl/sdram_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sdram_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ctrl.sv
// SDR SDRAM initiator: power-up init, periodic auto-refresh and close-page
// single-word accesses (ACTIVE, READ/WRITE burst of 2 halfwords, PRECHARGE).
module sdram_ctrl #(
    parameter int unsigned INIT_CYCLES      = 200,
    parameter int unsigned CAS_LATENCY      = 2,
    parameter int unsigned T_RCD            = 2,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RFC            = 7,
    parameter int unsigned T_MRD            = 2,
    parameter int unsigned T_WR             = 2,
    parameter int unsigned REFRESH_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        init_done,
    output logic        sdram_cke,
    output logic        sdram_cs,
    output logic        sdram_ras,
    output logic        sdram_cas,
    output logic        sdram_we,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic [1:0]  sdram_dqm,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    input  logic [15:0] sdram_dq_in
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REF_W = 16;
    localparam int unsigned A_W   = 13;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_INH = 4'b1111;

    localparam logic [A_W-1:0] A_PRE_ALL = 13'h0400;
    localparam logic [A_W-1:0] A_MODE    = {6'b0, 3'(CAS_LATENCY), 1'b0, 3'b001};

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_REF, S_ACT, S_RD, S_WR, S_WR_REC, S_PRE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [REF_W-1:0]  r_ref_cnt, w_ref_cnt_nxt;
    logic              r_ref_pend, w_ref_pend_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_we, w_we_nxt;
    logic [7:0]        r_col, w_col_nxt;
    logic [1:0]        r_bank, w_bank_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [3:0]        r_wstrb, w_wstrb_nxt;
    logic [15:0]       r_lo, w_lo_nxt;
    logic [3:0]        r_cmd, w_cmd_nxt;
    logic [A_W-1:0]    r_a, w_a_nxt;
    logic [1:0]        r_ba, w_ba_nxt;
    logic [1:0]        r_dqm, w_dqm_nxt;
    logic [15:0]       r_dq_out, w_dq_out_nxt;
    logic              r_dq_oe, w_dq_oe_nxt;
    logic              r_resp_valid, w_resp_nxt;
    logic [31:0]       r_rdata, w_rdata_nxt;
    logic              w_ref_hit;
    logic              w_unused_addr;

    assign w_unused_addr = ^{req_addr[31:25], req_addr[1:0]};
    assign w_ref_hit     = r_init_done && (r_ref_cnt == REF_W'(REFRESH_INTERVAL - 1));
    // Refresh due this cycle or already pending blocks new requests.
    assign req_ready     = (r_state == S_IDLE) && r_init_done && !r_ref_pend && !w_ref_hit;

    assign {sdram_cs, sdram_ras, sdram_cas, sdram_we} = r_cmd;
    assign sdram_cke    = 1'b1;
    assign sdram_a      = r_a;
    assign sdram_ba     = r_ba;
    assign sdram_dqm    = r_dqm;
    assign sdram_dq_out = r_dq_out;
    assign sdram_dq_oe  = r_dq_oe;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign init_done    = r_init_done;

    // Next-state, next-command and datapath decisions; pins are registered from these.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
        w_ref_cnt_nxt   = r_init_done ? (w_ref_hit ? '0 : r_ref_cnt + REF_W'(1)) : r_ref_cnt;
        w_ref_pend_nxt  = r_ref_pend | w_ref_hit;
        w_init_done_nxt = r_init_done;
        w_we_nxt        = r_we;
        w_col_nxt       = r_col;
        w_bank_nxt      = r_bank;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_lo_nxt        = r_lo;
        w_cmd_nxt       = CMD_NOP;
        w_a_nxt         = '0;
        w_ba_nxt        = r_ba;
        w_dqm_nxt       = 2'b11;
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = 1'b0;
        w_resp_nxt      = 1'b0;
        w_rdata_nxt     = r_rdata;

        case (r_state)
            S_INIT_WAIT: if (r_cnt == '0) begin
                w_cmd_nxt   = CMD_PRE;
                w_a_nxt     = A_PRE_ALL;
                w_state_nxt = S_INIT_PRE;
                w_cnt_nxt   = CNT_W'(T_RP - 1);
            end
            S_INIT_PRE: if (r_cnt == '0) begin
                w_cmd_nxt   = CMD_REF;
                w_state_nxt = S_INIT_REF1;
                w_cnt_nxt   = CNT_W'(T_RFC - 1);
            end
            S_INIT_REF1: if (r_cnt == '0) begin
                w_cmd_nxt   = CMD_REF;
                w_state_nxt = S_INIT_REF2;
                w_cnt_nxt   = CNT_W'(T_RFC - 1);
            end
            S_INIT_REF2: if (r_cnt == '0) begin
                w_cmd_nxt   = CMD_LMR;
                w_a_nxt     = A_MODE;
                w_state_nxt = S_INIT_MRS;
                w_cnt_nxt   = CNT_W'(T_MRD - 1);
            end
            S_INIT_MRS: if (r_cnt == '0) begin
                w_init_done_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            S_IDLE: begin
                if (r_ref_pend || w_ref_hit) begin
                    w_cmd_nxt   = CMD_REF;
                    w_state_nxt = S_REF;
                    w_cnt_nxt   = CNT_W'(T_RFC - 1);
                end else if (req_valid && req_ready) begin
                    w_we_nxt    = req_we;
                    w_col_nxt   = req_addr[9:2];
                    w_bank_nxt  = req_addr[11:10];
                    w_wdata_nxt = req_wdata;
                    w_wstrb_nxt = req_wstrb;
                    w_cmd_nxt   = CMD_ACT;
                    w_a_nxt     = req_addr[24:12];
                    w_ba_nxt    = req_addr[11:10];
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = CNT_W'(T_RCD - 1);
                end
            end
            S_REF: if (r_cnt == '0) begin
                w_ref_pend_nxt = w_ref_hit;
                w_state_nxt    = S_IDLE;
            end
            S_ACT: if (r_cnt == '0) begin
                w_a_nxt  = {4'b0, r_col, 1'b0};
                w_ba_nxt = r_bank;
                if (r_we) begin
                    w_cmd_nxt    = CMD_WR;
                    w_dq_oe_nxt  = 1'b1;
                    w_dq_out_nxt = r_wdata[15:0];
                    w_dqm_nxt    = ~r_wstrb[1:0];
                    w_state_nxt  = S_WR;
                end else begin
                    w_cmd_nxt   = CMD_RD;
                    w_dqm_nxt   = 2'b00;
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = CNT_W'(CAS_LATENCY + 1);
                end
            end
            S_RD: begin
                w_lo_nxt = sdram_dq_in;
                if (r_cnt != '0) begin
                    w_dqm_nxt = 2'b00;
                end else begin
                    w_resp_nxt  = 1'b1;
                    w_rdata_nxt = {sdram_dq_in, r_lo};
                    w_cmd_nxt   = CMD_PRE;
                    w_a_nxt     = A_PRE_ALL;
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = CNT_W'(T_RP - 1);
                end
            end
            S_WR: begin
                w_dq_oe_nxt  = 1'b1;
                w_dq_out_nxt = r_wdata[31:16];
                w_dqm_nxt    = ~r_wstrb[3:2];
                w_state_nxt  = S_WR_REC;
                w_cnt_nxt    = CNT_W'(T_WR - 1);
            end
            S_WR_REC: begin
                if (r_cnt == CNT_W'(T_WR - 1)) w_resp_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_cmd_nxt   = CMD_PRE;
                    w_a_nxt     = A_PRE_ALL;
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = CNT_W'(T_RP - 1);
                end
            end
            S_PRE: if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT_WAIT;
        endcase
    end

    // State, counters, latched request and registered pin drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_INIT_WAIT;
            r_cnt        <= CNT_W'(INIT_CYCLES);
            r_ref_cnt    <= '0;
            r_ref_pend   <= 1'b0;
            r_init_done  <= 1'b0;
            r_we         <= 1'b0;
            r_col        <= '0;
            r_bank       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_lo         <= '0;
            r_cmd        <= CMD_INH;
            r_a          <= '0;
            r_ba         <= '0;
            r_dqm        <= 2'b11;
            r_dq_out     <= '0;
            r_dq_oe      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ref_cnt    <= w_ref_cnt_nxt;
            r_ref_pend   <= w_ref_pend_nxt;
            r_init_done  <= w_init_done_nxt;
            r_we         <= w_we_nxt;
            r_col        <= w_col_nxt;
            r_bank       <= w_bank_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_lo         <= w_lo_nxt;
            r_cmd        <= w_cmd_nxt;
            r_a          <= w_a_nxt;
            r_ba         <= w_ba_nxt;
            r_dqm        <= w_dqm_nxt;
            r_dq_out     <= w_dq_out_nxt;
            r_dq_oe      <= w_dq_oe_nxt;
            r_resp_valid <= w_resp_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a small SDRAM device model on the pins.
module tb_sdram_ctrl;

    localparam int unsigned INIT_CYCLES = 200;
    localparam int unsigned CL          = 2;
    localparam int unsigned T_RCD       = 2;
    localparam int unsigned T_RP        = 2;
    localparam int unsigned T_RFC       = 7;
    localparam int unsigned T_MRD       = 2;
    localparam int unsigned T_WR        = 2;
    localparam int unsigned REF_INT     = 780;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_INH = 4'b1111;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        init_done;
    logic        sdram_cke;
    logic        sdram_cs;
    logic        sdram_ras;
    logic        sdram_cas;
    logic        sdram_we;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;
    logic [1:0]  sdram_dqm;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic [15:0] sdram_dq_in;
    logic [3:0]  cmd;

    assign cmd = {sdram_cs, sdram_ras, sdram_cas, sdram_we};

    sdram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .init_done(init_done),
        .sdram_cke(sdram_cke), .sdram_cs(sdram_cs), .sdram_ras(sdram_ras),
        .sdram_cas(sdram_cas), .sdram_we(sdram_we), .sdram_a(sdram_a),
        .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe), .sdram_dq_in(sdram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: per-bank open row, halfword memory, CL-delayed read data.
    logic [15:0] mem [int];
    logic [12:0] open_row [4];
    int          rd_k = -1;
    int          rd_key;
    int          wb_key;
    bit          wb2 = 1'b0;
    int          mkey;

    function automatic logic [15:0] peek(input int k);
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] m);
        return {m[1] ? old[15:8] : d[15:8], m[0] ? old[7:0] : d[7:0]};
    endfunction

    always @(negedge clk) begin
        if (wb2) begin
            if (sdram_dq_oe) mem[wb_key] = merge(peek(wb_key), sdram_dq_out, sdram_dqm);
            wb2 = 1'b0;
        end
        if (rd_k >= 0) begin
            rd_k++;
            if (rd_k == int'(CL)) sdram_dq_in = peek(rd_key);
            else if (rd_k == int'(CL) + 1) begin
                sdram_dq_in = peek(rd_key + 1);
                rd_k = -1;
            end
        end
        if (rst_n) begin
            mkey = int'({sdram_ba, open_row[sdram_ba], sdram_a[8:0]});
            case (cmd)
                C_ACT: open_row[sdram_ba] = sdram_a;
                C_WR: begin
                    if (sdram_dq_oe) mem[mkey] = merge(peek(mkey), sdram_dq_out, sdram_dqm);
                    wb_key = mkey + 1;
                    wb2    = 1'b1;
                end
                C_RD: begin
                    rd_key = mkey;
                    rd_k   = 0;
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [12:0] row;
        logic [1:0]  ba;
        logic [8:0]  col;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [8];
    vec_t        rb;
    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned t_done = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic next_cmd(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (cmd == C_NOP && gap < 2000);
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_wait", 32'(ok), 32'(1));
    endtask

    // Entered at the negedge right after rst_n is released.
    task automatic check_init();
        int n = 0;
        int gap;
        @(negedge clk);
        while (cmd == C_NOP && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("init_nops", 32'(n), 32'(INIT_CYCLES));
        chk("init_pre", 32'({cmd, sdram_a[10], init_done}), 32'({C_PRE, 1'b1, 1'b0}));
        next_cmd(gap);
        chk("init_trp", 32'(gap), 32'(T_RP));
        chk("init_ref1", 32'(cmd), 32'(C_REF));
        next_cmd(gap);
        chk("init_trfc1", 32'(gap), 32'(T_RFC));
        chk("init_ref2", 32'(cmd), 32'(C_REF));
        next_cmd(gap);
        chk("init_trfc2", 32'(gap), 32'(T_RFC));
        chk("init_mode", 32'({cmd, sdram_a}), 32'({C_LMR, 13'h021}));
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!init_done && gap < 50);
        chk("init_tmrd", 32'(gap), 32'(T_MRD));
        t_done = cyc;
    endtask

    // Caller is positioned at a negedge; presents the request and follows it through.
    task automatic txn(input vec_t v);
        int gap;
        bit oe_seen;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        req_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        chk("act", 32'({cmd, sdram_ba, sdram_a}), 32'({C_ACT, v.ba, v.row}));
        next_cmd(gap);
        chk("t_rcd", 32'(gap), 32'(T_RCD));
        chk("rw_cmd", 32'({cmd, sdram_ba, sdram_a}),
            32'({v.we ? C_WR : C_RD, v.ba, 4'b0000, v.col}));
        if (v.we) begin
            chk("beat0", 32'({sdram_dq_oe, sdram_dqm, sdram_dq_out}),
                32'({1'b1, ~v.wstrb[1:0], v.wdata[15:0]}));
            @(negedge clk);
            chk("beat1", 32'({cmd, sdram_dq_oe, sdram_dqm, sdram_dq_out}),
                32'({C_NOP, 1'b1, ~v.wstrb[3:2], v.wdata[31:16]}));
            @(negedge clk);
            chk("wr_resp", 32'({resp_valid, sdram_dq_oe, sdram_dqm}), 32'({1'b1, 1'b0, 2'b11}));
            chk("wr_rdata", resp_rdata, last_rd);
            next_cmd(gap);
            chk("t_wr", 32'(gap + 1), 32'(T_WR));
            chk("wr_pre", 32'({cmd, sdram_a[10], resp_valid}), 32'({C_PRE, 1'b1, 1'b0}));
        end else begin
            chk("rd_dqm", 32'({sdram_dq_oe, sdram_dqm}), 32'(0));
            gap = 0;
            oe_seen = 1'b0;
            do begin
                @(negedge clk);
                gap++;
                oe_seen |= sdram_dq_oe;
            end while (!resp_valid && gap < 20);
            chk("rd_lat", 32'(gap), 32'(CL + 2));
            chk("rd_data", resp_rdata, v.rdata);
            chk("rd_pre", 32'({cmd, sdram_a[10], oe_seen}), 32'({C_PRE, 1'b1, 1'b0}));
            last_rd = v.rdata;
            @(negedge clk);
            chk("rd_pulse", 32'(resp_valid), 32'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        vecs[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'b1111, 13'h0001, 2'd0, 9'h11A, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_1234, 32'h0,         4'b0000, 13'h0001, 2'd0, 9'h11A, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_1234, 32'h1122_3344, 4'b0100, 13'h0001, 2'd0, 9'h11A, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_1234, 32'h0,         4'b0000, 13'h0001, 2'd0, 9'h11A, 32'hDE22_BEEF};
        vecs[4] = '{1'b1, 32'h01FF_FFFC, 32'hCAFE_F00D, 4'b1111, 13'h1FFF, 2'd3, 9'h1FE, 32'h0};
        vecs[5] = '{1'b0, 32'h01FF_FFFC, 32'h0,         4'b0000, 13'h1FFF, 2'd3, 9'h1FE, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 32'hFE00_0C08, 32'hA5A5_5A5A, 4'b0000, 13'h0000, 2'd3, 9'h004, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_0C08, 32'h0,         4'b0000, 13'h0000, 2'd3, 9'h004, 32'h0};
        rb      = '{1'b0, 32'h0000_1234, 32'h0,         4'b0000, 13'h0001, 2'd0, 9'h11A, 32'hDE22_BEEF};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        sdram_dq_in = '0;

        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({cmd, sdram_cke, sdram_a, sdram_ba, sdram_dqm, sdram_dq_oe}),
            32'({C_INH, 1'b1, 13'h0, 2'b00, 2'b11, 1'b0}));
        chk("reset_bus", 32'({req_ready, resp_valid, init_done, sdram_dq_out}), 32'(0));
        chk("reset_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        check_init();

        for (int i = 0; i < 8; i++) txn(vecs[i]);

        // Request raised in the very cycle the refresh interval expires.
        while (cyc - t_done < REF_INT - 1) @(negedge clk);
        chk("ref_align", cyc - t_done, 32'(REF_INT - 1));
        req_we = rb.we;
        req_addr = rb.addr;
        req_valid = 1'b1;
        @(negedge clk);
        chk("ref_first", 32'({cmd, req_ready}), 32'({C_REF, 1'b0}));
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ref_trfc", 32'(n), 32'(T_RFC));
        txn(rb);

        // Reset one cycle after a READ command.
        req_we = 1'b0;
        req_addr = 32'h0000_1234;
        req_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        req_valid = 1'b0;
        next_cmd(gap);
        chk("mid_rd_cmd", 32'(cmd), 32'(C_RD));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_pins", 32'({cmd, sdram_dq_oe, init_done, resp_valid}),
            32'({C_INH, 1'b0, 1'b0, 1'b0}));
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("mid_rst_noresp", 32'(n), 32'(0));
        rst_n = 1'b1;
        last_rd = 32'h0;
        check_init();
        txn(rb);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
